// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: definitions shared by the RAM controller and its storage array.
//   - state encoding for the controller FSM (IDLE / WAIT / ACCESS)
//   - wait-state counter width and the largest supported wait-state count
//   - num_lanes(): byte lanes in a data word
package ram_ctrl_pkg;

    localparam int unsigned CNT_WIDTH       = 4;
    localparam int unsigned MAX_WAIT_STATES = 15;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WAIT   = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;

    function automatic int unsigned num_lanes(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_ctrl_array.sv
// ram_array: DEPTH x DATA_WIDTH storage with a byte-lane synchronous write port
// and a synchronous read port whose output register holds its value until the
// next read.
// Ports:
//   clock     rising-edge clock
//   reset     async active-high; clears the read register only, never the array
//   wr_en     write strobe (one cycle)
//   rd_en     read strobe (one cycle)
//   addr      word address, must be < DEPTH when a strobe is high
//   wr_data   write data
//   wr_lanes  per-byte write enables
//   rd_data   registered read data
module ram_array
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DEPTH      = 512
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_lanes,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int NUM_LANES = int'(num_lanes(DATA_WIDTH));

    // Zeroed at time 0 only; reset deliberately leaves the contents alone.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wr_lanes[i]) begin
                    mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: request/done front end for a single-port word RAM with a fixed,
// programmable access latency (WAIT_STATES extra cycles), byte-lane writes and
// out-of-range detection.
// Ports:
//   clock        rising-edge clock
//   reset        async active-high reset
//   req          access request, sampled only in IDLE
//   write        1 = write, 0 = read (sampled with req)
//   address      word address (sampled with req)
//   data         write data (sampled with req)
//   byte_en      per-byte write enables (sampled with req, ignored on reads)
//   busy         request in flight (WAIT or ACCESS)
//   done         one-cycle completion pulse
//   err          with done: latched address was >= DEPTH
//   data_output  last read data, updated only on an in-range read completion
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [DATA_WIDTH-1:0]   data_output
);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("ram_ctrl: DATA_WIDTH must be a multiple of 8");
    end
    if (ADDR_WIDTH >= 32 || DEPTH > (32'd1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("ram_ctrl: DEPTH must not exceed 2**ADDR_WIDTH");
    end
    if (WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait
        $error("ram_ctrl: WAIT_STATES must be in 0..15");
    end

    localparam logic [CNT_WIDTH-1:0] WAIT_INIT =
        (WAIT_STATES > 0) ? CNT_WIDTH'(WAIT_STATES - 1) : '0;

    state_t                  state, state_d;
    logic [CNT_WIDTH-1:0]    wait_cnt, wait_cnt_d;
    logic                    done_d, err_d;
    logic                    accept;
    logic                    in_range;
    logic                    lat_write;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_data;
    logic [DATA_WIDTH/8-1:0] lat_be;
    logic                    arr_wr, arr_rd;

    assign accept   = (state == ST_IDLE) && req;
    assign in_range = (32'(lat_addr) < DEPTH);
    assign busy     = (state == ST_WAIT) || (state == ST_ACCESS);

    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_INIT;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_d = ST_ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt - 1'b1;
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                err_d   = !in_range;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_be    <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            done     <= done_d;
            err      <= err_d;
            if (accept) begin
                lat_write <= write;
                lat_addr  <= address;
                lat_data  <= data;
                lat_be    <= byte_en;
            end
        end
    end

    // Array strobes exist only in ACCESS, so a reset before that edge drops the
    // pending request without touching storage.
    assign arr_wr = (state == ST_ACCESS) && lat_write && in_range;
    assign arr_rd = (state == ST_ACCESS) && !lat_write && in_range;

    ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (arr_wr),
        .rd_en    (arr_rd),
        .addr     (lat_addr),
        .wr_data  (lat_data),
        .wr_lanes (lat_be),
        .rd_data  (data_output)
    );

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: four instances with different DEPTH / WAIT_STATES, one
// reference word array per instance, directed plus randomised accesses.
module tb_ram_ctrl;

    localparam int N  = 4;
    localparam int UA = 0;  // defaults
    localparam int UB = 1;  // DEPTH = 300
    localparam int UC = 2;  // WAIT_STATES = 3
    localparam int UD = 3;  // WAIT_STATES = 0

    int ws_of    [N] = '{1, 1, 3, 0};
    int depth_of [N] = '{512, 300, 512, 512};

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        req   [N];
    logic        wr    [N];
    logic [8:0]  addr  [N];
    logic [31:0] wdata [N];
    logic [3:0]  be    [N];
    logic        busy  [N];
    logic        done  [N];
    logic        err   [N];
    logic [31:0] dout  [N];

    logic [31:0] ref_mem  [N][512];
    logic [31:0] ref_dout [N];

    int checks   = 0;
    int failures = 0;

    ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(512), .WAIT_STATES(1)) u_a (
        .clock(clock), .reset(reset), .req(req[UA]), .write(wr[UA]), .address(addr[UA]),
        .data(wdata[UA]), .byte_en(be[UA]), .busy(busy[UA]), .done(done[UA]),
        .err(err[UA]), .data_output(dout[UA]));
    ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(300), .WAIT_STATES(1)) u_b (
        .clock(clock), .reset(reset), .req(req[UB]), .write(wr[UB]), .address(addr[UB]),
        .data(wdata[UB]), .byte_en(be[UB]), .busy(busy[UB]), .done(done[UB]),
        .err(err[UB]), .data_output(dout[UB]));
    ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(512), .WAIT_STATES(3)) u_c (
        .clock(clock), .reset(reset), .req(req[UC]), .write(wr[UC]), .address(addr[UC]),
        .data(wdata[UC]), .byte_en(be[UC]), .busy(busy[UC]), .done(done[UC]),
        .err(err[UC]), .data_output(dout[UC]));
    ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(512), .WAIT_STATES(0)) u_d (
        .clock(clock), .reset(reset), .req(req[UD]), .write(wr[UD]), .address(addr[UD]),
        .data(wdata[UD]), .byte_en(be[UD]), .busy(busy[UD]), .done(done[UD]),
        .err(err[UD]), .data_output(dout[UD]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // err may only be seen together with done.
    always @(negedge clock) begin
        for (int u = 0; u < N; u++) begin
            if (done[u] !== 1'b1) chk($sformatf("err_without_done_u%0d", u), 32'(err[u]), 32'd0);
        end
    end

    task automatic chk_all_zero(input string tag);
        for (int u = 0; u < N; u++) begin
            chk($sformatf("%s_busy_u%0d", tag, u), 32'(busy[u]), 32'd0);
            chk($sformatf("%s_done_u%0d", tag, u), 32'(done[u]), 32'd0);
            chk($sformatf("%s_err_u%0d", tag, u), 32'(err[u]), 32'd0);
            chk($sformatf("%s_dout_u%0d", tag, u), dout[u], 32'd0);
        end
    endtask

    // One complete transaction on unit u, with expectations from the reference array.
    task automatic access(input int u, input bit w, input logic [8:0] a, input logic [31:0] d,
                          input logic [3:0] lanes, input string tag);
        int          n;
        bit          exp_err;
        logic [31:0] exp_dout;
        exp_err  = (int'(a) >= depth_of[u]);
        exp_dout = ref_dout[u];
        if (!exp_err) begin
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (lanes[i]) ref_mem[u][a][8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                exp_dout = ref_mem[u][a];
            end
        end
        ref_dout[u] = exp_dout;

        @(negedge clock);
        req[u] = 1'b1; wr[u] = w; addr[u] = a; wdata[u] = d; be[u] = lanes;
        @(posedge clock);
        #1;
        // Everything is latched; scramble the inputs to prove it.
        req[u] = 1'b0; wr[u] = 1'($urandom); addr[u] = 9'($urandom);
        wdata[u] = $urandom; be[u] = 4'($urandom);
        n = 0;
        while (n < 40) begin
            @(posedge clock);
            #1;
            n++;
            if (done[u] === 1'b1) break;
            chk({tag, "_busy_in_flight"}, 32'(busy[u]), 32'd1);
        end
        chk({tag, "_latency"}, 32'(n), 32'(ws_of[u] + 1));
        chk({tag, "_err"}, 32'(err[u]), 32'(exp_err));
        chk({tag, "_dout"}, dout[u], exp_dout);
        chk({tag, "_busy_at_done"}, 32'(busy[u]), 32'd0);
        @(posedge clock);
        #1;
        chk({tag, "_done_one_cycle"}, 32'(done[u]), 32'd0);
    endtask

    initial begin
        int          ndone;
        int          last;
        logic [31:0] v;

        for (int u = 0; u < N; u++) begin
            req[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; wdata[u] = '0; be[u] = '0;
            ref_dout[u] = '0;
            for (int k = 0; k < 512; k++) ref_mem[u][k] = '0;
        end

        #1 reset = 1'b1;
        #1 chk_all_zero("por");
        @(negedge clock);
        reset = 1'b0;

        // Reset during WAIT drops the pending write.
        @(negedge clock);
        req[UA] = 1'b1; wr[UA] = 1'b1; addr[UA] = 9'd7; wdata[UA] = 32'hCAFEF00D; be[UA] = 4'hF;
        @(posedge clock);
        #1 req[UA] = 1'b0;
        chk("rst_mid_busy", 32'(busy[UA]), 32'd1);
        #1 reset = 1'b1;
        #1 chk_all_zero("rst_mid");
        for (int c = 0; c < 2; c++) begin
            @(posedge clock);
            #1 chk("rst_hold_done", 32'(done[UA]), 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1 chk("rst_no_late_done", 32'(done[UA]), 32'd0);
        end
        for (int u = 0; u < N; u++) ref_dout[u] = '0;
        access(UA, 1'b0, 9'd7, $urandom, 4'hF, "rst_readback");
        chk("rst_readback_zero", dout[UA], 32'h0000_0000);

        // Basic write/read and byte lanes.
        access(UA, 1'b1, 9'h010, 32'hDEADBEEF, 4'hF, "a_wr10");
        access(UA, 1'b0, 9'h010, $urandom, 4'h0, "a_rd10");
        chk("a_rd10_const", dout[UA], 32'hDEADBEEF);
        access(UA, 1'b1, 9'd5, 32'h11223344, 4'hF, "a_wr5");
        access(UA, 1'b1, 9'd5, 32'hAABBCCDD, 4'b0101, "a_wr5_lanes");
        access(UA, 1'b1, 9'd5, 32'h55555555, 4'b0000, "a_wr5_nolanes");
        access(UA, 1'b0, 9'd5, $urandom, 4'hF, "a_rd5");
        chk("a_rd5_const", dout[UA], 32'h11BB33DD);

        // Out-of-range handling with DEPTH = 300.
        v = $urandom | 32'h1;
        access(UB, 1'b1, 9'd10, v, 4'hF, "b_wr10");
        access(UB, 1'b0, 9'd10, $urandom, 4'hF, "b_rd10");
        access(UB, 1'b1, 9'h150, $urandom, 4'hF, "b_wr_oor");
        access(UB, 1'b0, 9'h150, $urandom, 4'hF, "b_rd_oor");
        chk("b_rd_oor_hold", dout[UB], v);
        access(UB, 1'b1, 9'd300, $urandom, 4'hF, "b_wr300");
        access(UB, 1'b0, 9'd299, $urandom, 4'hF, "b_rd299");
        chk("b_rd299_zero", dout[UB], 32'd0);

        // WAIT_STATES = 0, top address.
        access(UD, 1'b1, 9'd511, $urandom, 4'hF, "d_wr511");
        access(UD, 1'b0, 9'd511, $urandom, 4'hF, "d_rd511");

        // WAIT_STATES = 3 streaming reads with req held/toggled while busy.
        for (int k = 0; k < 3; k++) access(UC, 1'b1, 9'(k), $urandom, 4'hF, "c_fill");
        @(negedge clock);
        req[UC] = 1'b1; wr[UC] = 1'b0; addr[UC] = 9'd0;
        @(posedge clock);
        ndone = 0;
        last  = -1;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (done[UC] === 1'b1) begin
                chk($sformatf("c_stream_dout%0d", ndone), dout[UC], ref_mem[UC][ndone]);
                if (last >= 0) chk("c_stream_spacing", 32'(c - last), 32'd5);
                ref_dout[UC] = ref_mem[UC][ndone];
                last = c;
                ndone++;
                req[UC]  = (ndone < 3);
                addr[UC] = 9'(ndone);
            end else if (ndone < 3) begin
                req[UC]  = 1'($urandom);
                addr[UC] = 9'($urandom);
                wr[UC]   = 1'($urandom);
            end else begin
                req[UC] = 1'b0;
            end
            @(posedge clock);
        end
        chk("c_stream_count", 32'(ndone), 32'd3);

        // Random mix across all units.
        for (int k = 0; k < 40; k++) begin
            int          u;
            logic [8:0]  a;
            u = int'($urandom_range(0, N - 1));
            if (u == UB) a = 9'($urandom_range(280, 320));
            else if ($urandom_range(0, 7) == 0) a = 9'd511;
            else a = 9'($urandom_range(0, 15));
            access(u, 1'($urandom), a, $urandom, 4'($urandom), $sformatf("rnd%0d_u%0d", k, u));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
